hazard_forwarding_controller: RTL
=================================

// Module: hazard_forwarding_controller
// PURPOSE
//  Sequencer for the segmented core's ALU operand path. Holds a shadow of the EX/MEM/WB destination info.
//  Drives forward_controller_1/2 of the ALU encapsulator, replacing the fixed 2'b00 / alu_src selects.
//  Detects load-use and (without forwarding) RAW hazards; stalls IF/ID, inserts ID/EX bubbles, handles branch flush.
// PARAMETERS
//  REG_ADDR_W  5   register index width
//  CNT_W       32  width of stall/flush performance counters
//  RF_BYPASS   1   1 = register file is write-before-read, so WB-stage producer is never a hazard
// PORTS
//  clk            in   1          core clock, rising edge
//  reset          in   1          asynchronous, active-high
//  id_rs1         in   REG_ADDR_W rs1 of instruction in ID
//  id_rs2         in   REG_ADDR_W rs2 of instruction in ID
//  id_use_rs1     in   1          ID instruction reads rs1
//  id_use_rs2     in   1          ID instruction reads rs2
//  id_rd          in   REG_ADDR_W destination of ID instruction
//  id_reg_write   in   1          ID instruction writes rd
//  id_mem_read    in   1          ID instruction is a load
//  id_alu_src     in   1          ID instruction uses immediate as operand B
//  ex_branch_taken in  1          branch/jump resolved taken in EX this cycle
//  forward_a      out  2          select for ALU operand A (EX stage)
//  forward_b      out  2          select for ALU operand B (EX stage)
//  pc_write_en    out  1          0 = hold PC
//  if_id_write_en out  1          0 = hold IF/ID register
//  if_id_flush    out  1          1 = clear IF/ID to NOP
//  id_ex_bubble   out  1          1 = load NOP into ID/EX
//  stall_cycles   out  CNT_W      cycles with pc_write_en=0
//  flush_count    out  CNT_W      number of taken-branch flushes
// BEHAVIOUR
//  Select encoding (pkg): 00 reg data, 01 prev_result_from_reg (EX/MEM ALU result), 10 prev_result_from_mux (WB mux), 11 immediate.
//  Shadow slots EX, MEM, WB: {valid, rd, reg_write, mem_read, rs1, rs2, use_rs1, use_rs2, alu_src}.
//  Each edge: MEM<=EX, WB<=MEM; EX<=ID fields, or invalid slot when id_ex_bubble=1.
//  forward_a/b: combinational from registered slots; valid in the cycle the consumer sits in EX (zero extra latency).
//  Forward A: EX.use_rs1 & MEM.reg_write & MEM.rd==EX.rs1 & rs1!=0 -> 01.
//   Otherwise the same test against WB -> 10; otherwise 00. The MEM-stage match wins (youngest producer).
//  Forward B: same as A on rs2, except EX.alu_src=1 forces 11.
//  Register x0 is never a hazard source nor forwarded.
//  Load-use: EX.valid & EX.mem_read & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
//   Result: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly 1 cycle, then forward 10 from WB.
//  Flush: ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1 for that cycle.
//   Flush beats a simultaneous stall: the stalled instruction is on the wrong path.
//  Counters: saturate at all-ones, never wrap.
//  Reset (async, immediate): slots invalid, forward_a/b=00, pc_write_en=1, if_id_write_en=1.
//   Also at reset: if_id_flush=0, id_ex_bubble=0, counters 0.
//   Reset mid-stall aborts the stall; no state survives.
// CONFIGURATION
//  Macro HAZARD_FORWARDING_EN.
//  Defined: behaviour as above.
//  Undefined: forward_a=00 always; forward_b=11 if alu_src else 00.
//   Any RAW on a used rs against a valid EX or MEM slot stalls (pc/if_id hold, bubble).
//   The WB slot also stalls when RF_BYPASS=0.
//   Stall holds until the producer leaves the checked stages: up to 2 cycles (3 with RF_BYPASS=0).
// STRUCTURE
//  Package hazard_pkg: fwd_sel_t enum (FWD_REG, FWD_EX_MEM, FWD_WB, FWD_IMM), stage_slot_t struct, REG_X0 constant.
//  Sub-module hazard_slot_pipe: the 3-deep shadow slot shift register with bubble insertion; the top holds compare/stall logic.
//  Wired by a new designator that feeds forward_a/b into the ALU encapsulator forward_controller_1/2.
// TESTING
//  1 add x5,x1,x2 ; sub x6,x5,x3 -> in sub's EX forward_a=01, no stall, stall_cycles=0.
//  2 add x5,.. ; nop ; or x7,x4,x5 -> forward_b=10 in or's EX; with addi x7,x5,4 -> forward_a=10, forward_b=11.
//  3 lw x5,0(x1) ; add x6,x5,x5 -> one cycle pc_write_en=0 & id_ex_bubble=1, then forward_a=forward_b=10; stall_cycles=1.
//  4 lw x5 ; add x6,x5 with ex_branch_taken=1 same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1, flush_count=1.
//  5 add x0,x1,x2 ; sub x6,x0,x0 -> forward_a=forward_b=00; assert reset during case-3 stall -> all outputs reset values at once.
//  6 HAZARD_FORWARDING_EN undefined, RF_BYPASS=1: add x5 ; sub x6,x5 -> 2 stall cycles, then forward_a=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared select encoding, shadow-slot layout and match helpers
// for the hazard/forwarding controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_REG    = 2'b00,
        FWD_EX_MEM = 2'b01,
        FWD_WB     = 2'b10,
        FWD_IMM    = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
        logic             alu_src;
    } stage_slot_t;

    localparam stage_slot_t EMPTY_SLOT = '0;

    // Slot s produces register r for a reader that really uses it; x0 never matches.
    function automatic logic writes_reg(stage_slot_t s, logic use_r, logic [REG_W-1:0] r);
        return s.valid & s.reg_write & use_r & (r == s.rd) & (r != REG_X0);
    endfunction

    function automatic fwd_sel_t pick_fwd(logic use_r, logic [REG_W-1:0] r,
                                          stage_slot_t mem, stage_slot_t wb);
        return writes_reg(mem, use_r, r) ? FWD_EX_MEM :
               writes_reg(wb, use_r, r)  ? FWD_WB : FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// hazard_slot_pipe: EX/MEM/WB shadow of in-flight instruction info;
// a bubble loads an empty slot into EX.
module hazard_slot_pipe
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  stage_slot_t id_slot,
    output stage_slot_t ex,
    output stage_slot_t mem,
    output stage_slot_t wb
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex  <= EMPTY_SLOT;
            mem <= EMPTY_SLOT;
            wb  <= EMPTY_SLOT;
        end else begin
            ex  <= bubble ? EMPTY_SLOT : id_slot;
            mem <= ex;
            wb  <= mem;
        end
    end

endmodule

// File: rtl/hazard_forwarding_controller.sv
// hazard_forwarding_controller: ALU operand forwarding selects, load-use/RAW stall
// and branch flush control. Macro HAZARD_FORWARDING_EN enables forwarding.
module hazard_forwarding_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int RF_BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_alu_src,
    input  logic                  ex_branch_taken,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    stage_slot_t id_s, ex_s, mem_s, wb_s;
    logic hazard, flush, stall;
    logic unused_ok;

    assign id_s = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read,
                    rs1: id_rs1, rs2: id_rs2, use_rs1: id_use_rs1, use_rs2: id_use_rs2,
                    alu_src: id_alu_src};

    hazard_slot_pipe u_pipe (
        .clk    (clk),
        .reset  (reset),
        .bubble (id_ex_bubble),
        .id_slot(id_s),
        .ex     (ex_s),
        .mem    (mem_s),
        .wb     (wb_s)
    );

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; everything else bypasses.
    assign hazard = ex_s.valid & ex_s.mem_read & (ex_s.rd != REG_X0) &
                    ((id_use_rs1 & (id_rs1 == ex_s.rd)) | (id_use_rs2 & (id_rs2 == ex_s.rd)));
    assign forward_a = pick_fwd(ex_s.use_rs1, ex_s.rs1, mem_s, wb_s);
    assign forward_b = ex_s.alu_src ? FWD_IMM : pick_fwd(ex_s.use_rs2, ex_s.rs2, mem_s, wb_s);
`else
    // Without bypass paths the consumer waits until the producer has written back.
    assign hazard = writes_reg(ex_s, id_use_rs1, id_rs1) | writes_reg(ex_s, id_use_rs2, id_rs2) |
                    writes_reg(mem_s, id_use_rs1, id_rs1) | writes_reg(mem_s, id_use_rs2, id_rs2) |
                    ((RF_BYPASS == 0) & (writes_reg(wb_s, id_use_rs1, id_rs1) |
                                         writes_reg(wb_s, id_use_rs2, id_rs2)));
    assign forward_a = FWD_REG;
    assign forward_b = ex_s.alu_src ? FWD_IMM : FWD_REG;
`endif

    // A taken branch discards the ID instruction, so it overrides any stall.
    assign flush          = ex_branch_taken & ~reset;
    assign stall          = hazard & ~flush;
    assign pc_write_en    = ~stall;
    assign if_id_write_en = ~stall;
    assign if_id_flush    = flush;
    assign id_ex_bubble   = stall | flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
            if (flush && ~&flush_count) flush_count <= flush_count + 1'b1;
        end
    end

    assign unused_ok = ^{ex_s, mem_s, wb_s, RF_BYPASS != 0};

endmodule
